// File: rtl/viterbi_pkg.sv
// Shared definitions for the rate-1/2 convolutional encoder and its decoder:
// default code parameters, the encoder state enum and the parity helper.
package viterbi_pkg;

  // Widest constraint length either block supports.
  localparam int MAX_K = 9;

  // Default code: K = 3, generators 7/5 (octal).
  localparam int         K_DEF  = 3;
  localparam logic [2:0] G0_DEF = 3'b111;
  localparam logic [2:0] G1_DEF = 3'b101;

  // RUN accepts information bits; TAIL flushes the register with zeros.
  typedef enum logic {
    RUN  = 1'b0,
    TAIL = 1'b1
  } enc_state_e;

  // One parity bit: XOR of the taps selected by generator g.
  // Callers zero-extend their K-bit vectors to MAX_K bits.
  function automatic logic parity(input logic [MAX_K-1:0] g,
                                  input logic [MAX_K-1:0] taps);
    return ^(g & taps);
  endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// Bit-in / symbol-out stream bundle of the convolutional encoder.
// The slave modport is the encoder's view; master is the environment's view.
interface conv_encoder_if;
  logic       s_valid;
  logic       s_ready;
  logic       s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [1:0] m_data;
  logic       m_last;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with a one-slot output register.
// Optional trellis termination (K-1 zero tail symbols after s_last) is
// compiled in when CONV_ENC_TAIL_EN is defined; otherwise the symbol of the
// s_last bit itself carries m_last and the register is cleared there.
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int           K  = K_DEF,
  parameter logic [K-1:0] G0 = K'(G0_DEF),
  parameter logic [K-1:0] G1 = K'(G1_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  conv_encoder_if.slave   bus,
  output logic            busy
);

  logic [K-2:0] sr;        // sr[0] is the most recent bit
  logic [K-1:0] taps;
  logic [1:0]   sym;
  logic         slot_free;
  logic         accept;
  logic         produce;
  logic         enc_in;
  logic         sym_last;

  // The output slot can take a new symbol when empty or being drained.
  assign slot_free = !bus.m_valid || bus.m_ready;
  assign accept    = bus.s_valid && bus.s_ready;

`ifdef CONV_ENC_TAIL_EN
  localparam int CW = $clog2(K);

  enc_state_e    state, state_nxt;
  logic [CW-1:0] tail_cnt;
  logic          tail_step;

  assign bus.s_ready = slot_free && (state == RUN);
  assign tail_step   = slot_free && (state == TAIL);
  assign sym_last    = tail_step && (tail_cnt == CW'(K - 2));
  assign enc_in      = tail_step ? 1'b0 : bus.s_data;
  assign produce     = accept || tail_step;
  assign busy        = (state == TAIL);

  // State register and count of tail symbols already issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      tail_cnt <= '0;
    end else begin
      // NOTE: registers use non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      state <= state_nxt;
      if (sym_last)
        tail_cnt <= '0;
      else if (tail_step)
        tail_cnt <= tail_cnt + CW'(1);
    end
  end

  // Next state: enter TAIL on the frame's last bit, leave after the flush.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:  if (accept && bus.s_last) state_nxt = TAIL;
      TAIL: if (sym_last)             state_nxt = RUN;
    endcase
  end
`else
  assign bus.s_ready = slot_free;
  assign sym_last    = accept && bus.s_last;
  assign enc_in      = bus.s_data;
  assign produce     = accept;
  assign busy        = 1'b0;
`endif

  // Tap vector {in, sr[0], ..., sr[K-2]} and the two parity bits.
  always_comb begin
    // NOTE: every bit gets a value before the loop so no latch is inferred.
    taps        = '0;
    taps[K-1]   = enc_in;
    for (int i = 0; i < K - 1; i++)
      taps[K-2-i] = sr[i];
    sym[1] = parity(MAX_K'(G0), MAX_K'(taps));
    sym[0] = parity(MAX_K'(G1), MAX_K'(taps));
  end

  // Shift register: shift on every produced symbol, restart at zero after
  // the frame's final symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sr <= '0;
    else if (produce)
      sr <= sym_last ? '0 : {sr[K-3:0], enc_in};
  end

  // Single-slot output register; holds its contents under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_valid <= 1'b0;
      bus.m_data  <= 2'b00;
      bus.m_last  <= 1'b0;
    end else if (produce) begin
      bus.m_valid <= 1'b1;
      bus.m_data  <= sym;
      bus.m_last  <= sym_last;
    end else if (bus.m_ready) begin
      bus.m_valid <= 1'b0;
    end
  end

endmodule
